// File: rtl/cache_pkg.sv
// Shared state encoding, line geometry and helpers for the direct-mapped cache.
package cache_pkg;

    localparam int LINE_BYTES  = 16;
    localparam int OFFSET_BITS = 4;
    localparam int LINE_BITS   = LINE_BYTES * 8;

    localparam logic MEM_RW_READ  = 1'b0;
    localparam logic MEM_RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        READY,
        WB_REQ,
        FILL_REQ,
        FILL_WAIT
    } state_t;

    function automatic logic [LINE_BITS-1:0] merge_word(
        input logic [LINE_BITS-1:0] line,
        input logic [1:0]           sel,
        input logic [3:0]           be,
        input logic [31:0]          data
    );
        logic [LINE_BITS-1:0] r;
        r = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                r[{sel, b[1:0], 3'b000} +: 8] = data[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/dirty/tag/data storage: one combinational read port, one write port
// that either installs a whole line or merges bytes of one word.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int TAG_W     = 24,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic                 install,
    input  logic [TAG_W-1:0]     install_tag,
    input  logic [LINE_BITS-1:0] install_line,
    input  logic                 store,
    input  logic [1:0]           store_word,
    input  logic [3:0]           store_be,
    input  logic [31:0]          store_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (install) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= 1'b0;
        end else if (store) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data are left unreset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[wr_idx]  <= install_tag;
            data_q[wr_idx] <= install_line;
        end else if (store) begin
            data_q[wr_idx] <= merge_word(data_q[wr_idx], store_word,
                                         store_be, store_data);
        end
    end

endmodule

// File: rtl/dmapped_cache.sv
// Direct-mapped, write-back, write-allocate blocking cache with 16-byte lines
// and a single-beat 128-bit valid/ready memory port.
module dmapped_cache
    import cache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic                  stall,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-5:0] mem_req_addr,
    output logic [127:0]          mem_req_data,
    input  logic                  mem_resp_valid,
    input  logic [127:0]          mem_resp_data
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS - IDX_W;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [3:0]            we_r;
    logic [31:0]           din_r;
    logic                  pending;
    logic [31:0]           dout_q;

    logic [IDX_W-1:0]     idx_r;
    logic [TAG_W-1:0]     tag_r;
    logic [1:0]           word_r;
    logic                 line_valid;
    logic                 line_dirty;
    logic [TAG_W-1:0]     line_tag;
    logic [LINE_BITS-1:0] line_data;
    logic [31:0]          rd_word;
    logic                 hit;
    logic                 hit_cycle;
    logic                 unused_ok;

    assign idx_r     = addr_r[OFFSET_BITS +: IDX_W];
    assign tag_r     = addr_r[ADDR_WIDTH-1 -: TAG_W];
    assign word_r    = addr_r[3:2];
    assign unused_ok = ^addr_r[1:0];

    assign hit       = line_valid && (line_tag == tag_r);
    assign hit_cycle = (state_q == READY) && pending && hit;
    assign stall     = (state_q != READY) || (pending && !hit);
    assign rd_word   = line_data[{word_r, 5'd0} +: 32];

    // Load data is visible combinationally in the hit cycle (pre-store),
    // and held from the register otherwise.
    assign dout = hit_cycle ? rd_word : dout_q;

    cache_line_array #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W)
    ) u_lines (
        .clk          (clk),
        .reset        (reset),
        .rd_idx       (idx_r),
        .rd_valid     (line_valid),
        .rd_dirty     (line_dirty),
        .rd_tag       (line_tag),
        .rd_line      (line_data),
        .wr_idx       (idx_r),
        .install      ((state_q == FILL_WAIT) && mem_resp_valid),
        .install_tag  (tag_r),
        .install_line (mem_resp_data),
        .store        (hit_cycle && (we_r != 4'b0000)),
        .store_word   (word_r),
        .store_be     (we_r),
        .store_data   (din_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= READY;
            pending <= 1'b0;
            addr_r  <= '0;
            we_r    <= '0;
            din_r   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            if (!stall) begin
                addr_r  <= addr;
                we_r    <= we;
                din_r   <= din;
                pending <= re || (we != 4'b0000);
            end
            if (hit_cycle) begin
                dout_q <= rd_word;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        mem_req_rw    = MEM_RW_READ;
        mem_req_addr  = addr_r[ADDR_WIDTH-1:OFFSET_BITS];
        unique case (state_q)
            READY: begin
                if (pending && !hit) begin
                    state_d = (line_valid && line_dirty) ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = MEM_RW_WRITE;
                mem_req_addr  = {line_tag, idx_r};
                if (mem_req_ready) begin
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = READY;
                end
            end
            default: state_d = READY;
        endcase
    end

    assign mem_req_data = line_data;

endmodule

// File: tb/tb_dmapped_cache.sv
// Scoreboard bench: a flat memory image model predicts every load result.
module tb_dmapped_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  addr;
    logic         re;
    logic [3:0]   we;
    logic [31:0]  din;
    logic [31:0]  dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    always #5 clk = ~clk;

    dmapped_cache #(.NUM_LINES(16), .ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .addr           (addr),
        .re             (re),
        .we             (we),
        .din            (din),
        .dout           (dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    int checks = 0;
    int errs   = 0;

    // Backing memory (written-back lines) and the CPU-visible image on top.
    logic [127:0] mem [int unsigned];
    logic [31:0]  ovl [int unsigned];
    logic [31:0]  exp_q [$];
    logic [28:0]  hs_log [$];

    int rdy_mode   = 1;
    bit drop_resp  = 1'b0;
    int inject_req = 0;
    bit mon_live   = 1'b0;
    bit mon_load   = 1'b0;
    int last_wait  = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gen_word(int unsigned line, int unsigned k);
        if (line == 4) return 32'h11111111 * (k + 1);
        return (line * 32'h9E3779B1) ^ (32'h01010101 * k) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [127:0] mem_line(int unsigned line);
        logic [127:0] r;
        if (mem.exists(line)) return mem[line];
        for (int k = 0; k < 4; k++) r[32*k +: 32] = gen_word(line, k);
        return r;
    endfunction

    function automatic logic [31:0] mword(int unsigned line, int unsigned k);
        logic [127:0] l;
        if (ovl.exists(line * 4 + k)) return ovl[line * 4 + k];
        l = mem_line(line);
        return l[32*k +: 32];
    endfunction

    function automatic logic [127:0] img_line(int unsigned line);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = mword(line, k);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re = 1'b0;
        we = 4'b0000;
    endtask

    task automatic issue(input logic [31:0] a, input logic r,
                         input logic [3:0] w, input logic [31:0] d);
        int unsigned line;
        int unsigned k;
        logic [31:0] old;
        int n;
        line = {4'b0, a[31:4]};
        k    = {30'b0, a[3:2]};
        addr = a;
        re   = r;
        we   = w;
        din  = d;
        old  = mword(line, k);
        if (r) exp_q.push_back(old);
        if (w != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (w[b]) old[8*b +: 8] = d[8*b +: 8];
            ovl[line * 4 + k] = old;
        end
        n = 0;
        @(negedge clk);
        while (stall && n < 400) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (stall) begin
            checks++;
            errs++;
            $display("FAIL accept: stall=%b after %0d cycles, required 0", stall, n);
        end
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mon_live && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (mon_live) begin
            checks++;
            errs++;
            $display("FAIL drain: request still open after %0d cycles, required done", n);
        end
        #1;
    endtask

    // Monitor: the first stall-free cycle after acceptance carries the result.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_live = 1'b0;
            end else begin
                if (mon_live && !stall) begin
                    mon_live = 1'b0;
                    if (mon_load) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errs++;
                            $display("FAIL dout: got %h with no load expected", dout);
                        end else begin
                            chk("dout", 128'(dout), 128'(exp_q.pop_front()));
                        end
                    end
                end
                if (!stall && (re || we != 4'b0000)) begin
                    mon_live = 1'b1;
                    mon_load = re;
                end
            end
        end
    end

    // Memory responder with configurable backpressure and response delay.
    initial begin
        logic         hs, rst_seen, h_rw, have, prev_wait;
        logic [27:0]  h_addr, resp_line, p_addr;
        logic [127:0] h_data;
        logic         p_rw;
        int           resp_cnt, inject_done;
        have = 1'b0;
        prev_wait = 1'b0;
        inject_done = 0;
        resp_cnt = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            hs       = mem_req_valid && mem_req_ready && !reset;
            rst_seen = reset;
            h_rw     = mem_req_rw;
            h_addr   = mem_req_addr;
            h_data   = mem_req_data;
            if (prev_wait && mem_req_valid && !reset) begin
                chk("req_stable", {99'b0, h_rw, h_addr}, {99'b0, p_rw, p_addr});
            end
            prev_wait = mem_req_valid && !mem_req_ready && !reset;
            p_rw      = h_rw;
            p_addr    = h_addr;
            @(posedge clk);
            #2;
            mem_resp_valid = 1'b0;
            if (rst_seen) have = 1'b0;
            if (hs) begin
                hs_log.push_back({h_rw, h_addr});
                if (h_rw) begin
                    chk("wb_data", h_data, img_line({4'b0, h_addr}));
                    mem[{4'b0, h_addr}] = h_data;
                end else begin
                    have      = 1'b1;
                    resp_line = h_addr;
                    resp_cnt  = $urandom_range(0, 3);
                end
            end else if (have) begin
                if (resp_cnt == 0) begin
                    have = 1'b0;
                    if (!drop_resp) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = mem_line({4'b0, resp_line});
                    end
                end else begin
                    resp_cnt--;
                end
            end
            if (inject_req != inject_done) begin
                inject_done    = inject_req;
                mem_resp_valid = 1'b1;
                mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            case (rdy_mode)
                0:       mem_req_ready = ($urandom_range(0, 3) != 0);
                2:       mem_req_ready = 1'b0;
                default: mem_req_ready = 1'b1;
            endcase
        end
    end

    initial begin
        reset = 1'b1;
        addr  = '0;
        re    = 1'b0;
        we    = 4'b0000;
        din   = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_req_valid", 128'(mem_req_valid), 128'(0));
        chk("rst_dout", 128'(dout), 128'(0));
        step();

        // Cold load miss
        rdy_mode = 2;
        issue(32'h40, 1'b1, 4'b0000, 32'h0);
        idle();
        @(negedge clk);
        chk("t1_stall", 128'(stall), 128'(1));
        step();
        @(negedge clk);
        chk("t1_req", {98'b0, stall, mem_req_valid, mem_req_rw, mem_req_addr},
            {98'b0, 1'b1, 1'b1, 1'b0, 28'h4});
        step();
        rdy_mode = 1;
        drain();

        // Hits, back to back
        issue(32'h44, 1'b1, 4'b0000, 32'h0);
        chk("t2_hit_wait", 128'(last_wait), 128'(0));
        issue(32'h48, 1'b1, 4'b0000, 32'h0);
        chk("t2_b2b_48", 128'(last_wait), 128'(0));
        issue(32'h4C, 1'b1, 4'b0000, 32'h0);
        chk("t2_b2b_4c", 128'(last_wait), 128'(0));
        idle();
        drain();

        // Store merge then reload
        issue(32'h40, 1'b0, 4'b0011, 32'h0000BEEF);
        issue(32'h40, 1'b1, 4'b0000, 32'h0);
        chk("t3_store_nostall", 128'(last_wait), 128'(0));
        idle();
        drain();

        // Dirty conflict: writeback then fill
        hs_log.delete();
        issue(32'h140, 1'b1, 4'b0000, 32'h0);
        idle();
        drain();
        chk("t4_nreq", 128'(hs_log.size()), 128'(2));
        if (hs_log.size() == 2) begin
            chk("t4_wb", 128'(hs_log[0]), 128'({1'b1, 28'h4}));
            chk("t4_fill", 128'(hs_log[1]), 128'({1'b0, 28'h14}));
        end

        // Backpressure in FILL_REQ
        rdy_mode = 2;
        issue(32'h80, 1'b1, 4'b0000, 32'h0);
        idle();
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold", {98'b0, stall, mem_req_valid, mem_req_rw, mem_req_addr},
                {98'b0, 1'b1, 1'b1, 1'b0, 28'h8});
            step();
        end
        rdy_mode = 1;
        drain();

        // Reset while waiting for the fill
        drop_resp = 1'b1;
        issue(32'h240, 1'b1, 4'b0000, 32'h0);
        idle();
        repeat (6) step();
        @(negedge clk);
        chk("t6_in_wait", {126'b0, stall, mem_req_valid}, {126'b0, 1'b1, 1'b0});
        step();
        reset = 1'b1;
        exp_q.delete();
        ovl.delete();
        step();
        reset = 1'b0;
        drop_resp = 1'b0;
        @(negedge clk);
        chk("t6_after_rst", {95'b0, stall, mem_req_valid, dout},
            {95'b0, 1'b0, 1'b0, 32'h0});
        step();
        inject_req++;
        repeat (3) step();
        hs_log.delete();
        issue(32'h40, 1'b1, 4'b0000, 32'h0);
        idle();
        @(negedge clk);
        chk("t6_miss", 128'(stall), 128'(1));
        step();
        drain();
        chk("t6_nreq", 128'(hs_log.size()), 128'(1));
        if (hs_log.size() == 1) chk("t6_fill", 128'(hs_log[0]), 128'({1'b0, 28'h4}));

        // Randomized traffic over 4 aliases per index
        rdy_mode = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            int unsigned op;
            logic [3:0] w;
            a  = {22'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 2'b00};
            op = $urandom_range(0, 19);
            w  = 4'($urandom_range(1, 15));
            if (op < 10)      issue(a, 1'b1, 4'b0000, $urandom);
            else if (op < 17) issue(a, 1'b0, w, $urandom);
            else              issue(a, 1'b1, w, $urandom);
            if ($urandom_range(0, 4) == 0) begin
                idle();
                step();
            end
        end
        idle();
        drain();
        chk("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/dmapped_cache.md
Name: dmapped_cache

Overview:
- Memory-side responder for the core's cache ports (addr, re, we, din, dout, stall).
- Direct-mapped, write-back, write-allocate blocking cache with 16-byte lines.
- Instantiated once for instruction fetch (we tied 0) and once for data.
- Misses are serviced over a single-beat, 128-bit valid/ready main-memory interface while the core is held with stall.

Parameters:
- NUM_LINES, 16, number of lines; power of two ≥ 2; index = addr[3+log2(NUM_LINES):4].
- ADDR_WIDTH, 32, byte-address width; tag = addr[ADDR_WIDTH-1:4+log2(NUM_LINES)].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addr  in  ADDR_WIDTH  CPU byte address (word-aligned)
- re  in  1  CPU read request
- we  in  4  CPU byte write enables
- din  in  32  CPU store data
- dout  out  32  load data
- stall  out  1  core must hold its inputs and state while high
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  1 = line write (writeback), 0 = line read (fill)
- mem_req_addr  out  ADDR_WIDTH-4  line address
- mem_req_data  out  128  writeback line; meaningful only when rw=1
- mem_resp_valid  in  1  fill data valid (one cycle)
- mem_resp_data  in  128  fill line; word k = bits [32k+31:32k]

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - Reset is synchronous and active-high (reset).
  - Reset values: state=READY, pending=0, all valid and dirty bits=0, stall=0, mem_req_valid=0, dout=0.
  - Tag/data contents are not reset.
- Request acceptance:
  - At a rising edge with stall=0, the block registers addr/re/we/din into the request register.
  - pending = re | (we≠0).
  - While stall=1, inputs are ignored.
- Lookup (READY with pending):
  - hit = valid[idx] & (tag[idx]==tag_r).
  - stall = (state≠READY) | (pending & !hit), computed from registered state only.
- Hit cycle (stall=0):
  - dout = word addr_r[3:2] of the line. This is pre-store data if we is also set.
  - If we≠0, the enabled bytes of din are merged at the edge and dirty[idx] is set.
  - A new request may be accepted in the same cycle, giving back-to-back single-cycle hits.
- Latency:
  - Hit: data in the cycle after acceptance.
  - Clean miss: 3 cycles plus memory waits.
  - Dirty miss: adds the writeback handshake.
- FSM:
  - READY:
    - On miss with valid & dirty → WB_REQ.
    - On miss otherwise → FILL_REQ.
  - WB_REQ:
    - Drives mem_req_valid=1, rw=1, addr={tag[idx],idx}, data=line[idx].
    - On mem_req_ready → FILL_REQ.
  - FILL_REQ:
    - Drives mem_req_valid=1, rw=0, addr=addr_r[ADDR_WIDTH-1:4].
    - On mem_req_ready → FILL_WAIT.
  - FILL_WAIT:
    - On mem_resp_valid, installs the line: data, tag, valid=1, dirty=0.
    - Then → READY, where the pending request replays as a hit (store merge happens in the replay).
- Handshake rules:
  - mem_req_* outputs are stable while valid=1 and ready=0.
  - valid drops in the cycle after the handshake.
  - mem_resp_valid outside FILL_WAIT is ignored.
- Boundaries:
  - re and we both set: treated as a store; dout still returns the old word.
  - Same-index back-to-back requests after a store hit see the merged data.
  - Reset mid-miss: returns to the reset state at the next edge; the outstanding memory response is ignored.
- dout holds its last value in non-hit cycles. Consumers sample it only in the cycle following a load acceptance when stall=0.

Decomposition:
- Shared package cache_pkg:
  - state encoding (READY, WB_REQ, FILL_REQ, FILL_WAIT)
  - LINE_BYTES=16, OFFSET_BITS=4
  - MEM_RW_READ=0, MEM_RW_WRITE=1
- Sub-module cache_line_array:
  - valid/dirty/tag/data flops with one read port (index) and one write port.
  - Write port takes full-line install or word/byte-merge.
  - Valid/dirty are cleared by reset.

Test Plan:
1. Cold load miss: after reset, re=1 addr=0x40 → next cycle stall=1; mem_req_valid=1 rw=0 mem_req_addr=0x0000004; return data with word0=0x11111111 → replay cycle stall=0, dout=0x11111111.
2. Load hit, other word: re=1 addr=0x44 (word1=0x22222222) → no stall, dout=0x22222222 next cycle. Back-to-back loads to 0x48 then 0x4C complete one per cycle.
3. Store merge: we=4'b0011 din=0x0000BEEF addr=0x40 → no stall; then load 0x40 → dout=0x1111BEEF.
4. Dirty conflict: re=1 addr=0x140 (index 4) → WB request rw=1, addr=0x0000004, data word0=0x1111BEEF; then fill request addr=0x0000014; then replay → dout equals fill word0.
5. Memory backpressure: mem_req_ready held 0 for 5 cycles in FILL_REQ → stall=1 throughout; mem_req_valid and mem_req_addr constant; completes after ready=1.
6. Reset during FILL_WAIT → next cycle stall=0 and mem_req_valid=0. A late mem_resp_valid is ignored. A subsequent load to 0x40 misses, since valid bits were cleared.
